// File: rtl/mem_dport_bridge.sv
// Load/store front end for the shared async-read scratchpad: word-aligned accesses with byte masks,
// lane extraction/extension of load data, 1-entry registered response. Optional counters: MEM_DPORT_BRIDGE_PERF_EN.
module mem_dport_bridge #(
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic                    req_fcn,
    input  logic [2:0]              req_typ,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_mask,
    output logic                    mem_wen,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef MEM_DPORT_BRIDGE_PERF_EN
    ,
    output logic [31:0]             perf_ld_cnt,
    output logic [31:0]             perf_st_cnt,
    output logic [31:0]             perf_err_cnt
`endif
);

    localparam int unsigned MASK_W = DATA_WIDTH / 8;

    localparam logic [2:0] TYP_B  = 3'd1;
    localparam logic [2:0] TYP_H  = 3'd2;
    localparam logic [2:0] TYP_W  = 3'd3;
    localparam logic [2:0] TYP_BU = 3'd5;
    localparam logic [2:0] TYP_HU = 3'd6;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("mem_dport_bridge supports DATA_WIDTH == 32 only");
        end
    endgenerate

    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q,   resp_err_d;

    logic [1:0]            off;
    logic                  fire;
    logic                  err;
    logic                  typ_ok;
    logic                  misalign;
    logic [MASK_W-1:0]     mask_base;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;

    assign off       = req_addr[1:0];
    assign req_ready = !resp_valid_q || resp_ready;
    assign fire      = req_valid && req_ready;
    assign mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign lane      = mem_rdata >> {off, 3'b000};

    // Access-type decode: lane mask, replicated store data, alignment check, load extension
    always_comb begin
        typ_ok    = 1'b1;
        misalign  = 1'b0;
        mask_base = '0;
        wdata_rep = '0;
        load_ext  = '0;
        case (req_typ)
            TYP_B, TYP_BU: begin
                mask_base = MASK_W'(4'b0001);
                wdata_rep = {4{req_wdata[7:0]}};
                load_ext  = (req_typ == TYP_B) ? {{24{lane[7]}}, lane[7:0]}
                                               : {24'd0, lane[7:0]};
            end
            TYP_H, TYP_HU: begin
                mask_base = MASK_W'(4'b0011);
                wdata_rep = {2{req_wdata[15:0]}};
                misalign  = off[0];
                load_ext  = (req_typ == TYP_H) ? {{16{lane[15]}}, lane[15:0]}
                                               : {16'd0, lane[15:0]};
            end
            TYP_W: begin
                mask_base = MASK_W'(4'b1111);
                wdata_rep = req_wdata;
                misalign  = (off != 2'd0);
                load_ext  = lane;
            end
            default: typ_ok = 1'b0;
        endcase
        err = !typ_ok || misalign;
    end

    assign mem_mask  = mask_base << off;
    assign mem_wdata = wdata_rep;
    // Gated by rst_n so a store colliding with reset never reaches the memory
    assign mem_wen   = fire && req_fcn && !err && rst_n;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (fire) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = (req_fcn || err) ? '0 : load_ext;
            resp_err_d   = err;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

`ifdef MEM_DPORT_BRIDGE_PERF_EN
    logic [31:0] perf_ld_q, perf_st_q, perf_err_q;

    // Errored accesses count only as errors, never as loads or stores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ld_q  <= '0;
            perf_st_q  <= '0;
            perf_err_q <= '0;
        end else if (fire) begin
            if (err)          perf_err_q <= perf_err_q + 32'd1;
            else if (req_fcn) perf_st_q  <= perf_st_q + 32'd1;
            else              perf_ld_q  <= perf_ld_q + 32'd1;
        end
    end

    assign perf_ld_cnt  = perf_ld_q;
    assign perf_st_cnt  = perf_st_q;
    assign perf_err_cnt = perf_err_q;
`endif

endmodule
